traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter RED_CYCLES, default 20, SHALL set the required consecutive red-only samples per phase.
REQ-002 Parameter GREEN_CYCLES, default 15, SHALL set the required consecutive green-only samples per phase.
REQ-003 Parameter YELLOW_CYCLES, default 5, SHALL set the required consecutive yellow-only samples per phase.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-006 Ports red, green, yellow  input  1 each  SHALL be the observed lamp signals, sampled on each rising edge of clk.
REQ-007 Port phase  output  2  SHALL encode the tracked state: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW.
REQ-008 Port locked  output  1  SHALL be high while a verified full period precedes the current phase.
REQ-009 Port cycle_done  output  1  SHALL be a one-cycle pulse when a complete RED-GREEN-YELLOW period verifies.
REQ-010 Ports err_onehot, err_seq, err_dur  output  1 each  SHALL be one-cycle error pulses.
REQ-011 Port err_sticky  output  1  SHALL latch high on any error pulse until reset.
REQ-012 Port err_count  output  8  SHALL count error events, saturating at 255.

Function
REQ-013 All outputs SHALL be registered; a decision on the sample taken at edge k SHALL appear immediately after edge k.
REQ-014 Sample vector L = {red,green,yellow}; L SHALL be valid only when exactly one bit is set.
REQ-015 A previous-sample register prevL SHALL hold the last L, reset to 3'b000.
REQ-016 Dwell counter SHALL be sized to hold max(RED_CYCLES,GREEN_CYCLES,YELLOW_CYCLES) and SHALL never wrap.
REQ-017 SYNC: on red onset (L==100 and prevL!=100), go to RED with dwell=1; otherwise remain in SYNC.
REQ-018 In state X (RED/GREEN/YELLOW) with required count N_X, L==X and dwell<N_X SHALL increment dwell.
REQ-019 L==X and dwell==N_X (overrun) SHALL pulse err_dur and go to SYNC.
REQ-020 L==legal successor (RED->GREEN->YELLOW->RED) and dwell==N_X SHALL advance, dwell=1.
REQ-021 L==legal successor and dwell!=N_X (short phase) SHALL pulse err_dur and go to SYNC.
REQ-022 L valid but neither X nor successor SHALL pulse err_seq and go to SYNC.
REQ-023 L invalid (zero or multiple bits) SHALL pulse err_onehot, in any state including SYNC; tracked states go to SYNC.
REQ-024 At most one error pulse per edge; priority err_onehot > err_seq > err_dur.
REQ-025 Legal YELLOW->RED advance SHALL pulse cycle_done and set locked.
REQ-026 locked SHALL clear on the edge of any error pulse and while in SYNC.
REQ-027 err_count SHALL increment by 1 per error pulse, hold at 255.
REQ-028 A red onset coinciding with the error edge SHALL NOT resync; resync requires a later red onset sampled in SYNC.
REQ-029 A red-only sample on the first edge after reset release SHALL count as an onset (prevL=000).

Reset
REQ-030 rst high SHALL immediately force phase=0, dwell=0, prevL=000, locked=0, cycle_done=0, all err pulses=0, err_sticky=0, err_count=0.
REQ-031 Reset asserted mid-operation SHALL abort tracking with no error pulse; monitoring restarts at SYNC.

Verification
REQ-032 Reset, then red 20/green 15/yellow 5 for 3 periods -> phase 1,2,3 in sequence; cycle_done at each yellow->red edge (3 pulses); locked=1 after first; err_count=0.
REQ-033 Locked, green held 16 samples -> err_dur on 16th green edge; phase=0; locked=0; err_count=1; err_sticky=1.
REQ-034 Yellow 4 samples then red -> err_dur on red edge, phase=0; red continues, no resync until next red onset; next nominal period -> phase follows, cycle_done again.
REQ-035 Red 20 then yellow -> err_seq, phase=0; red&green both high 1 cycle -> err_onehot; all lamps off 1 cycle in SYNC -> err_onehot, phase stays 0.
REQ-036 rst asserted mid-GREEN (dwell 7) -> all outputs 0 without waiting for clk; release with red-only -> phase=1 next edge.
REQ-037 300 invalid samples (L=000) -> err_count=255 and held; err_onehot pulses every cycle; err_sticky=1.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: checks that the lamps cycle RED -> GREEN -> YELLOW with exact dwell times,
// then reports lock, completed periods and one-hot/sequence/duration errors.
module traffic_light_monitor #(
    parameter int unsigned RED_CYCLES    = 20,
    parameter int unsigned GREEN_CYCLES  = 15,
    parameter int unsigned YELLOW_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       green,
    input  logic       yellow,
    output logic [1:0] phase,
    output logic       locked,
    output logic       cycle_done,
    output logic       err_onehot,
    output logic       err_seq,
    output logic       err_dur,
    output logic       err_sticky,
    output logic [7:0] err_count
);

    localparam int unsigned MAX_RG     = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
    localparam int unsigned DW         = $clog2(MAX_CYCLES + 1);

    localparam logic [DW-1:0] N_RED    = DW'(RED_CYCLES);
    localparam logic [DW-1:0] N_GREEN  = DW'(GREEN_CYCLES);
    localparam logic [DW-1:0] N_YELLOW = DW'(YELLOW_CYCLES);
    localparam logic [DW-1:0] ONE      = DW'(1);

    localparam logic [1:0] SYNC   = 2'd0;
    localparam logic [1:0] RED    = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_GREEN  = 3'b010;
    localparam logic [2:0] L_YELLOW = 3'b001;

    logic [2:0]    lamps;
    logic [2:0]    prev_lamps;
    logic [DW-1:0] dwell;
    logic          valid;
    logic [2:0]    cur_lamp;
    logic [2:0]    succ_lamp;
    logic [1:0]    succ_phase;
    logic [DW-1:0] need;

    logic [1:0]    next_phase;
    logic [DW-1:0] next_dwell;
    logic          next_locked;
    logic          cd_d;
    logic          eo_d;
    logic          es_d;
    logic          ed_d;
    logic          err_any;

    assign lamps = {red, green, yellow};
    assign valid = $onehot(lamps);

    always_comb begin
        cur_lamp   = '0;
        succ_lamp  = '0;
        succ_phase = SYNC;
        need       = '0;
        case (phase)
            RED: begin
                cur_lamp   = L_RED;
                succ_lamp  = L_GREEN;
                succ_phase = GREEN;
                need       = N_RED;
            end
            GREEN: begin
                cur_lamp   = L_GREEN;
                succ_lamp  = L_YELLOW;
                succ_phase = YELLOW;
                need       = N_GREEN;
            end
            YELLOW: begin
                cur_lamp   = L_YELLOW;
                succ_lamp  = L_RED;
                succ_phase = RED;
                need       = N_YELLOW;
            end
            default: ;
        endcase
    end

    // Error checks are ordered so at most one error pulse fires per edge (onehot > seq > dur).
    always_comb begin
        next_phase  = phase;
        next_dwell  = dwell;
        next_locked = locked;
        cd_d        = 1'b0;
        eo_d        = 1'b0;
        es_d        = 1'b0;
        ed_d        = 1'b0;
        if (!valid) begin
            eo_d       = 1'b1;
            next_phase = SYNC;
            next_dwell = '0;
        end else if (phase == SYNC) begin
            if (lamps == L_RED && prev_lamps != L_RED) begin
                next_phase = RED;
                next_dwell = ONE;
            end
        end else if (lamps == cur_lamp) begin
            if (dwell < need) begin
                next_dwell = dwell + ONE;
            end else begin
                ed_d       = 1'b1;
                next_phase = SYNC;
                next_dwell = '0;
            end
        end else if (lamps == succ_lamp) begin
            if (dwell == need) begin
                next_phase = succ_phase;
                next_dwell = ONE;
                if (phase == YELLOW) begin
                    cd_d        = 1'b1;
                    next_locked = 1'b1;
                end
            end else begin
                ed_d       = 1'b1;
                next_phase = SYNC;
                next_dwell = '0;
            end
        end else begin
            es_d       = 1'b1;
            next_phase = SYNC;
            next_dwell = '0;
        end
        err_any = eo_d | es_d | ed_d;
        if (err_any || next_phase == SYNC) begin
            next_locked = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= SYNC;
            dwell      <= '0;
            prev_lamps <= '0;
            locked     <= 1'b0;
            cycle_done <= 1'b0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            err_dur    <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            phase      <= next_phase;
            dwell      <= next_dwell;
            prev_lamps <= lamps;
            locked     <= next_locked;
            cycle_done <= cd_d;
            err_onehot <= eo_d;
            err_seq    <= es_d;
            err_dur    <= ed_d;
            if (err_any) begin
                err_sticky <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp sequences,
// checked every cycle against a behavioural model of the phase rules.
module tb_traffic_light_monitor;

    localparam int RC = 20;
    localparam int GC = 15;
    localparam int YC = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       red = 1'b0;
    logic       green = 1'b0;
    logic       yellow = 1'b0;
    logic [1:0] phase;
    logic       locked;
    logic       cycle_done;
    logic       err_onehot;
    logic       err_seq;
    logic       err_dur;
    logic       err_sticky;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int cd_seen = 0;
    bit chk_en = 1'b0;

    // Behavioural model state: phase index 0..3, time spent in the phase, last sample.
    int         m_phase;
    int         m_dwell;
    logic [2:0] m_prev;
    bit         m_locked, m_cd, m_eo, m_es, m_ed, m_sticky;
    int         m_cnt;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .RED_CYCLES   (RC),
        .GREEN_CYCLES (GC),
        .YELLOW_CYCLES(YC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .red       (red),
        .green     (green),
        .yellow    (yellow),
        .phase     (phase),
        .locked    (locked),
        .cycle_done(cycle_done),
        .err_onehot(err_onehot),
        .err_seq   (err_seq),
        .err_dur   (err_dur),
        .err_sticky(err_sticky),
        .err_count (err_count)
    );

    function automatic logic [2:0] lamp_of(input int p);
        case (p)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int need_of(input int p);
        case (p)
            1:       return RC;
            2:       return GC;
            3:       return YC;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_dwell = 0; m_prev = 3'b000;
        m_locked = 0; m_cd = 0; m_eo = 0; m_es = 0; m_ed = 0;
        m_sticky = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [2:0] l);
        int nxt;
        nxt = m_phase % 3 + 1;
        m_cd = 0; m_eo = 0; m_es = 0; m_ed = 0;
        if ($countones(l) != 1) begin
            m_eo = 1; m_phase = 0;
        end else if (m_phase == 0) begin
            if (l == 3'b100 && m_prev != 3'b100) begin
                m_phase = 1; m_dwell = 1;
            end
        end else if (l == lamp_of(m_phase)) begin
            if (m_dwell < need_of(m_phase)) m_dwell++;
            else begin m_ed = 1; m_phase = 0; end
        end else if (l == lamp_of(nxt)) begin
            if (m_dwell == need_of(m_phase)) begin
                if (m_phase == 3) begin m_cd = 1; m_locked = 1; end
                m_phase = nxt; m_dwell = 1;
            end else begin
                m_ed = 1; m_phase = 0;
            end
        end else begin
            m_es = 1; m_phase = 0;
        end
        if (m_eo || m_es || m_ed) begin
            m_sticky = 1;
            m_locked = 0;
            if (m_cnt < 255) m_cnt++;
        end
        if (m_phase == 0) m_locked = 0;
        m_prev = l;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase",      int'(phase),      m_phase);
            check("locked",     int'(locked),     int'(m_locked));
            check("cycle_done", int'(cycle_done), int'(m_cd));
            check("err_onehot", int'(err_onehot), int'(m_eo));
            check("err_seq",    int'(err_seq),    int'(m_es));
            check("err_dur",    int'(err_dur),    int'(m_ed));
            check("err_sticky", int'(err_sticky), int'(m_sticky));
            check("err_count",  int'(err_count),  m_cnt);
            if (cycle_done === 1'b1) cd_seen++;
        end
    end

    task automatic step(input logic [2:0] l);
        {red, green, yellow} = l;
        @(posedge clk);
        model_step(l);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic period();
        run(3'b100, RC);
        run(3'b010, GC);
        run(3'b001, YC);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_phase",     int'(phase),      0);
        check("rst_locked",    int'(locked),     0);
        check("rst_err_count", int'(err_count),  0);
        check("rst_sticky",    int'(err_sticky), 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Three nominal periods, closed by the red onset of the fourth.
        for (int p = 0; p < 3; p++) period();
        step(3'b100);
        check("p3_cd_count",  cd_seen,          3);
        check("p3_locked",    int'(locked),     1);
        check("p3_err_count", int'(err_count),  0);
        check("p3_phase",     int'(phase),      1);

        // Green overrun on the 16th green sample.
        run(3'b100, RC - 1);
        run(3'b010, GC + 1);
        check("ovr_err_dur",  int'(err_dur),    1);
        check("ovr_phase",    int'(phase),      0);
        check("ovr_locked",   int'(locked),     0);
        check("ovr_count",    int'(err_count),  1);
        check("ovr_sticky",   int'(err_sticky), 1);

        // Short yellow; red on the error edge must not resync.
        run(3'b100, RC);
        run(3'b010, GC);
        run(3'b001, YC - 1);
        step(3'b100);
        check("short_err_dur", int'(err_dur),   1);
        check("short_phase",   int'(phase),     0);
        run(3'b100, 5);
        check("noresync_phase", int'(phase),    0);
        run(3'b010, 3);
        period();
        step(3'b100);
        check("resync_cd_count", cd_seen,       4);
        check("resync_phase",    int'(phase),   1);

        // Wrong successor, then invalid samples.
        run(3'b100, RC - 1);
        step(3'b001);
        check("seq_err",    int'(err_seq),    1);
        check("seq_phase",  int'(phase),      0);
        step(3'b110);
        check("multi_onehot", int'(err_onehot), 1);
        step(3'b000);
        check("zero_onehot",  int'(err_onehot), 1);
        check("zero_phase",   int'(phase),      0);
        check("err_count_5",  int'(err_count),  5);

        // Asynchronous reset in the middle of green.
        run(3'b100, RC);
        run(3'b010, 7);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_phase",  int'(phase),      0);
        check("arst_count",  int'(err_count),  0);
        check("arst_sticky", int'(err_sticky), 0);
        check("arst_errs",   int'({err_onehot, err_seq, err_dur, cycle_done, locked}), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step(3'b100);
        check("arst_release_phase", int'(phase), 1);

        // Error counter saturation.
        run(3'b000, 300);
        check("sat_count",  int'(err_count),  255);
        check("sat_sticky", int'(err_sticky), 1);
        check("sat_onehot", int'(err_onehot), 1);

        // Randomized periods with dwell jitter and occasional corrupted samples.
        do_reset();
        for (int p = 0; p < 40; p++) begin
            for (int ph = 1; ph <= 3; ph++) begin
                int len;
                int r;
                len = need_of(ph);
                r = int'($urandom_range(0, 9));
                if (r == 0) len = len - 1;
                else if (r == 1) len = len + 1;
                for (int i = 0; i < len; i++) begin
                    logic [2:0] l;
                    l = lamp_of(ph);
                    if ($urandom_range(0, 149) == 0) l = 3'($urandom_range(0, 7));
                    step(l);
                end
            end
        end
        step(3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
